// File: rtl/uart_tx_responder.sv
// uart_tx_responder: memory-mapped 8N1 UART transmitter with a TX FIFO, answering core bus reads/writes.
// Optional macro UART_TX_IRQ_EN adds a CTRL register at BASE+16 and a level "TX drained" irq output.
module uart_tx_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic        uart_tx,
  output logic        tx_busy
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_d;
  logic               pop;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]      count_q;
  logic               full, empty;
  logic               push, drop;
  logic               ovf_q;

  logic               hit_data, hit_status, wr_data, rd_status;
  logic [63:0]        status_word;
  logic [63:0]        rdata_d;
  logic               unused_wdata;

  assign unused_wdata = ^bus_write_data[63:8];

  assign hit_data   = (bus_address == BASE_ADDR);
  assign hit_status = (bus_address == BASE_ADDR + 64'd8);
  assign wr_data    = bus_write_enable & hit_data;
  assign rd_status  = bus_read_enable & hit_status;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == CW'(0));
  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted then.
  assign push  = wr_data & (~full | pop);
  assign drop  = wr_data & full & ~pop;

  assign status_word = {48'd0, 8'(count_q), 4'd0, ovf_q, tx_busy, empty, full};

`ifdef UART_TX_IRQ_EN
  logic hit_ctrl;
  logic irq_en_q;

  assign hit_ctrl = (bus_address == BASE_ADDR + 64'd16);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (bus_write_enable & hit_ctrl) irq_en_q <= bus_write_data[0];
      irq <= irq_en_q & empty & (state_q == S_IDLE);
    end
  end
`endif

  // Read mux; anything other than a mapped register read returns 0.
  always_comb begin
    rdata_d = '0;
    if (bus_read_enable) begin
      if (hit_status) rdata_d = status_word;
`ifdef UART_TX_IRQ_EN
      else if (hit_ctrl) rdata_d = {63'd0, irq_en_q};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_write_data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      bus_read_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      ovf_q         <= (ovf_q & ~rd_status) | drop;
      bus_read_data <= rdata_d;
    end
  end

  // Serialiser: line value is registered from the next state so it lines up with the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          cnt_d   = CNT_MAX;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_MAX;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_MAX;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      uart_tx <= tx_d;
      tx_busy <= (state_q != S_IDLE) | ~empty;
    end
  end

endmodule
